// File: rtl/segway_pkg.sv
// Shared state encoding and default timing constants for the segway power sequencer.
package segway_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RAMP  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FAULT = 2'd3
    } seg_state_e;

    localparam int SS_PRESC_DEF  = 4;
    localparam int STEER_DLY_DEF = 16;
    localparam int FAST_LIM_DEF  = 4;

    localparam logic [7:0] SS_TMR_MAX = 8'hFF;

    // Bits needed to hold a counter that saturates at max_val.
    function automatic int cntr_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/segway_sequencer_sat_cntr.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_cntr #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    input  logic [W-1:0] sat_max,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] r_cnt;

    // NOTE: flops are written with <= so every register in the design samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt < sat_max)) begin
            r_cnt <= r_cnt + ONE;
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/segway_sequencer.sv
// Segway power sequencer: soft-start ramp, delayed steering enable and latched overspeed shutdown.
module segway_sequencer
    import segway_pkg::*;
#(
    parameter int SS_PRESC  = SS_PRESC_DEF,
    parameter int STEER_DLY = STEER_DLY_DEF,
    parameter int FAST_LIM  = FAST_LIM_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pwr_req,
    input  logic       rider_on,
    input  logic       steer_ok,
    input  logic       vld,
    input  logic       too_fast,
    output logic       pwr_up,
    output logic [7:0] ss_tmr,
    output logic       en_steer,
    output logic       fault
);

    localparam int STEER_W = cntr_width(STEER_DLY);
    localparam int FAST_W  = cntr_width(FAST_LIM);

    localparam logic [STEER_W-1:0]  STEER_MAX = STEER_W'(STEER_DLY);
    localparam logic [STEER_W-1:0]  STEER_THR = STEER_W'(STEER_DLY - 1);
    localparam logic [FAST_W-1:0]   FAST_MAX  = FAST_W'(FAST_LIM);
    localparam logic [FAST_W-1:0]   FAST_THR  = FAST_W'(FAST_LIM - 1);
    localparam logic [SS_PRESC-1:0] PRESC_ONE = SS_PRESC'(1);

    seg_state_e          r_state;
    logic [SS_PRESC-1:0] r_presc;
    logic [7:0]          r_ss_tmr;
    logic                r_pwr_up;
    logic                r_en_steer;
    logic                r_fault;

    logic [STEER_W-1:0]  w_steer_cnt;
    logic [FAST_W-1:0]   w_fast_cnt;
    logic                w_in_run;
    logic                w_pwr_down;
    logic                w_fast_hit;
    logic                w_leave_run;
    logic                w_steer_inc;
    logic                w_steer_clr;
    logic                w_steer_hit;
    logic                w_fast_inc;
    logic                w_fast_clr;

    assign w_in_run    = (r_state == ST_RUN);
    assign w_pwr_down  = !pwr_req || !rider_on;
    // Hit fires on the sample that would bring the count to its limit, so the fault lands on that edge.
    assign w_fast_hit  = w_in_run && vld && too_fast && (w_fast_cnt >= FAST_THR);
    assign w_leave_run = w_in_run && (w_pwr_down || w_fast_hit);

    // Counters only move in RUN and are held clear everywhere else, which covers every state change.
    assign w_steer_inc = w_in_run && steer_ok;
    assign w_steer_clr = !w_in_run || w_leave_run || !steer_ok;
    assign w_steer_hit = w_steer_inc && (w_steer_cnt >= STEER_THR);
    assign w_fast_inc  = w_in_run && vld && too_fast;
    assign w_fast_clr  = !w_in_run || w_leave_run || (vld && !too_fast);

    sat_cntr #(.W(STEER_W)) u_steer_cntr (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (w_steer_inc),
        .clr     (w_steer_clr),
        .sat_max (STEER_MAX),
        .cnt     (w_steer_cnt)
    );

    sat_cntr #(.W(FAST_W)) u_fast_cntr (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (w_fast_inc),
        .clr     (w_fast_clr),
        .sat_max (FAST_MAX),
        .cnt     (w_fast_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_presc    <= '0;
            r_ss_tmr   <= '0;
            r_pwr_up   <= 1'b0;
            r_en_steer <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_presc    <= '0;
                    r_ss_tmr   <= '0;
                    r_en_steer <= 1'b0;
                    r_fault    <= 1'b0;
                    if (pwr_req && rider_on) begin
                        r_state  <= ST_RAMP;
                        r_pwr_up <= 1'b1;
                    end
                end

                ST_RAMP: begin
                    if (w_pwr_down) begin
                        r_state  <= ST_IDLE;
                        r_pwr_up <= 1'b0;
                        r_presc  <= '0;
                        r_ss_tmr <= '0;
                    end else begin
                        r_presc <= r_presc + PRESC_ONE;
                        if (r_ss_tmr == SS_TMR_MAX) begin
                            r_state <= ST_RUN;
                        end else if (&r_presc) begin
                            r_ss_tmr <= r_ss_tmr + 8'd1;
                            if (r_ss_tmr == (SS_TMR_MAX - 8'd1)) begin
                                r_state <= ST_RUN;
                            end
                        end
                    end
                end

                ST_RUN: begin
                    // Losing power or rider outranks an overspeed hit in the same cycle.
                    if (w_pwr_down) begin
                        r_state    <= ST_IDLE;
                        r_pwr_up   <= 1'b0;
                        r_presc    <= '0;
                        r_ss_tmr   <= '0;
                        r_en_steer <= 1'b0;
                    end else if (w_fast_hit) begin
                        r_state    <= ST_FAULT;
                        r_pwr_up   <= 1'b0;
                        r_presc    <= '0;
                        r_ss_tmr   <= '0;
                        r_en_steer <= 1'b0;
                        r_fault    <= 1'b1;
                    end else begin
                        r_ss_tmr   <= SS_TMR_MAX;
                        r_en_steer <= w_steer_hit;
                    end
                end

                ST_FAULT: begin
                    if (!pwr_req) begin
                        r_state <= ST_IDLE;
                        r_fault <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign pwr_up   = r_pwr_up;
    assign ss_tmr   = r_ss_tmr;
    assign en_steer = r_en_steer;
    assign fault    = r_fault;

endmodule
